alu_exec: RTL and testbench

//  Execute-stage ALU consuming the 4-bit `ALU_* control code produced by ALU control decode.

---
 rtl/alu_exec_if.sv | 32 +++
 rtl/alu_exec.sv | 191 +++++++++++++++++++
 tb/tb_alu_exec.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// alu_exec_if: request/result handshake bundle for the execute-stage ALU.
//   master : request producer / result consumer (drives i_*, observes o_*)
//   slave  : the ALU itself (observes i_*, drives o_*)
// Signals:
//   i_flush  abort any op in flight        i_valid/o_ready  request handshake
//   i_aluctl 4-bit ALU control code        i_a/i_b          operands
//   o_valid/i_ready  result handshake      o_result/o_zero/o_divz  result + flags
interface alu_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [3:0]       i_aluctl;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_zero;
  logic             o_divz;

  modport master (
    output i_flush, i_valid, i_aluctl, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_zero, o_divz
  );

  modport slave (
    input  i_flush, i_valid, i_aluctl, i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_zero, o_divz
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU. Single-cycle ops (logic, add/sub, shifts,
// compares) complete on the accept edge; MUL/DIV/MOD iterate one bit per
// cycle for WIDTH cycles. Valid/ready on both sides; i_flush aborts.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      alu_exec_if slave: i_flush, i_valid/o_ready, i_aluctl, i_a, i_b,
//            o_valid/i_ready, o_result, o_zero, o_divz
module alu_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  alu_exec_if.slave bus
);
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_SLA = 4'd9;
  localparam logic [3:0] ALU_SIE = 4'd10;
  localparam logic [3:0] ALU_SIL = 4'd11;
  localparam logic [3:0] ALU_MUL = 4'd12;
  localparam logic [3:0] ALU_DIV = 4'd13;
  localparam logic [3:0] ALU_MOD = 4'd14;

  // WIDTH is a power of two, so the final iteration index is all ones.
  localparam logic [SHW-1:0] LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] a_q;      // original dividend, for MOD by zero
  logic [WIDTH-1:0] acc_q;    // MUL: partial product; DIV/MOD: remainder
  logic [WIDTH-1:0] x_q;      // MUL: multiplicand;    DIV/MOD: dividend -> quotient
  logic [WIDTH-1:0] y_q;      // MUL: multiplier;      DIV/MOD: divisor magnitude
  logic             qneg_q, rneg_q, bz_q;
  logic             valid_q, zero_q, divz_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] single_d, fin_d, acc_d, x_d, a_mag, b_mag, sll_tmp;
  logic [WIDTH:0]   rem_sh, trial;
  logic [SHW-1:0]   sh;
  logic             long_op;

  assign sh      = bus.i_b[SHW-1:0];
  assign a_mag   = bus.i_a[WIDTH-1] ? -bus.i_a : bus.i_a;
  assign b_mag   = bus.i_b[WIDTH-1] ? -bus.i_b : bus.i_b;
  assign long_op = (bus.i_aluctl == ALU_MUL) || (bus.i_aluctl == ALU_DIV) ||
                   (bus.i_aluctl == ALU_MOD);

  // Single-cycle result, computed straight from the request inputs.
  always_comb begin
    single_d = '0;
    sll_tmp  = bus.i_a << sh;
    case (bus.i_aluctl)
      ALU_ADD: single_d = bus.i_a + bus.i_b;
      ALU_SUB: single_d = bus.i_a - bus.i_b;
      ALU_AND: single_d = bus.i_a & bus.i_b;
      ALU_OR:  single_d = bus.i_a | bus.i_b;
      ALU_XOR: single_d = bus.i_a ^ bus.i_b;
      ALU_NOR: single_d = ~(bus.i_a | bus.i_b);
      ALU_SLL: single_d = sll_tmp;
      ALU_SRL: single_d = bus.i_a >> sh;
      ALU_SRA: single_d = $unsigned($signed(bus.i_a) >>> sh);
      ALU_SLA: single_d = {bus.i_a[WIDTH-1], sll_tmp[WIDTH-2:0]};
      ALU_SIE: single_d = {{(WIDTH-1){1'b0}}, bus.i_a == bus.i_b};
      ALU_SIL: single_d = {{(WIDTH-1){1'b0}}, $signed(bus.i_a) < $signed(bus.i_b)};
      default: single_d = '0;
    endcase
  end

  // One iteration step: shift-add multiply or restoring-division step.
  always_comb begin
    acc_d  = acc_q;
    x_d    = x_q;
    rem_sh = '0;
    trial  = '0;
    if (op_q == ALU_MUL) begin
      if (y_q[0]) acc_d = acc_q + x_q;
      x_d = x_q << 1;
    end else begin
      rem_sh = {acc_q, x_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, y_q};
      if (!trial[WIDTH]) begin
        acc_d = trial[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Final long-op result, taken from the last iteration's step output so the
  // result registers in the same edge as the WIDTH-th iteration.
  always_comb begin
    fin_d = '0;
    case (op_q)
      ALU_MUL: fin_d = acc_d;
      ALU_DIV: fin_d = bz_q ? '1 : (qneg_q ? -x_d : x_d);
      default: fin_d = bz_q ? a_q : (rneg_q ? -acc_d : acc_d);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      divz_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.i_flush) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_valid) begin
            op_q <= bus.i_aluctl;
            a_q  <= bus.i_a;
            if (long_op) begin
              state_q <= S_CALC;
              cnt_q   <= '0;
              acc_q   <= '0;
              qneg_q  <= bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1];
              rneg_q  <= bus.i_a[WIDTH-1];
              bz_q    <= (bus.i_b == '0);
              if (bus.i_aluctl == ALU_MUL) begin
                x_q <= bus.i_a;
                y_q <= bus.i_b;
              end else begin
                x_q <= a_mag;
                y_q <= b_mag;
              end
            end else begin
              state_q  <= S_DONE;
              result_q <= single_d;
              zero_q   <= (single_d == '0);
              divz_q   <= 1'b0;
              valid_q  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          x_q   <= x_d;
          if (op_q == ALU_MUL) y_q <= y_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q  <= S_DONE;
            result_q <= fin_d;
            zero_q   <= (fin_d == '0);
            divz_q   <= bz_q & (op_q != ALU_MUL);
            valid_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.i_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready  = (state_q == S_IDLE);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_zero   = zero_q;
  assign bus.o_divz   = divz_q;
endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
  localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  AND_ = 4'd2, OR_ = 4'd3;
  localparam logic [3:0] XOR_ = 4'd4, NOR_ = 4'd5, SLL = 4'd6,  SRL = 4'd7;
  localparam logic [3:0] SRA = 4'd8,  SLA = 4'd9,  SIE = 4'd10, SIL = 4'd11;
  localparam logic [3:0] MUL = 4'd12, DIV = 4'd13, MOD = 4'd14, UND = 4'd15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_exec_if #(.WIDTH(32)) bus ();

  alu_exec #(.WIDTH(32), .SHW(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        dz;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model straight from the op definitions, using 64-bit signed
  // arithmetic so the most-negative / -1 case truncates naturally.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic dz);
    longint sa, sb;
    logic [31:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t  = a << b[4:0];
    dz = 1'b0;
    case (op)
      ADD:  r = a + b;
      SUB:  r = a - b;
      AND_: r = a & b;
      OR_:  r = a | b;
      XOR_: r = a ^ b;
      NOR_: r = ~(a | b);
      SLL:  r = t;
      SRL:  r = a >> b[4:0];
      SRA:  r = 32'(sa >>> b[4:0]);
      SLA:  r = {a[31], t[30:0]};
      SIE:  r = (a == b) ? 32'd1 : 32'd0;
      SIL:  r = (sa < sb) ? 32'd1 : 32'd0;
      MUL:  r = a * b;
      DIV:  begin if (b == 0) begin r = '1; dz = 1'b1; end else r = 32'(sa / sb); end
      MOD:  begin if (b == 0) begin r = a;  dz = 1'b1; end else r = 32'(sa % sb); end
      default: r = '0;
    endcase
  endfunction

  // Issue one request at a negedge, measure latency, optionally hold i_ready
  // low for `hold` cycles with junk requests offered, then accept the result.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ez,
                       input logic edz, input int hold);
    int lat, g, elat;
    logic rdy_low;
    g = 0;
    while (!bus.o_ready && g < 50) begin @(negedge clk); g++; end
    chk({name, " ready_before"}, 32'(bus.o_ready), 32'd1);
    bus.i_aluctl = op; bus.i_a = a; bus.i_b = b; bus.i_valid = 1'b1; bus.i_ready = 1'b0;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_a = $urandom; bus.i_b = $urandom; bus.i_aluctl = 4'($urandom_range(0, 15));
    lat = 1;
    rdy_low = 1'b1;
    while (!bus.o_valid && lat < 100) begin
      if (bus.o_ready) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    elat = (op == MUL || op == DIV || op == MOD) ? 33 : 1;
    chk({name, " latency"}, 32'(lat), 32'(elat));
    chk({name, " result"}, bus.o_result, er);
    chk({name, " zero"}, 32'(bus.o_zero), 32'(ez));
    chk({name, " divz"}, 32'(bus.o_divz), 32'(edz));
    chk({name, " ready_low"}, 32'(rdy_low & ~bus.o_ready), 32'd1);
    for (int i = 0; i < hold; i++) begin
      bus.i_valid = 1'b1; bus.i_aluctl = ADD; bus.i_a = $urandom; bus.i_b = $urandom;
      @(negedge clk);
      chk({name, " hold_valid"}, 32'(bus.o_valid), 32'd1);
      chk({name, " hold_result"}, bus.o_result, er);
      chk({name, " hold_ready"}, 32'(bus.o_ready), 32'd0);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    chk({name, " drop_valid"}, 32'(bus.o_valid), 32'd0);
    chk({name, " ready_after"}, 32'(bus.o_ready), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r, a, b;
    logic        dz, seen;
    logic [3:0]  op;

    vecs[0]  = '{ADD,  32'd7,          32'hFFFF_FFFD, 32'd4,          1'b0, 1'b0};
    vecs[1]  = '{SUB,  32'd5,          32'd5,         32'd0,          1'b1, 1'b0};
    vecs[2]  = '{MUL,  32'hFFFF_FFFF,  32'd3,         32'hFFFF_FFFD,  1'b0, 1'b0};
    vecs[3]  = '{DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD,  1'b0, 1'b0};
    vecs[4]  = '{MOD,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[5]  = '{DIV,  32'd5,          32'd0,         32'hFFFF_FFFF,  1'b0, 1'b1};
    vecs[6]  = '{MOD,  32'd5,          32'd0,         32'd5,          1'b0, 1'b1};
    vecs[7]  = '{SRA,  32'h8000_0000,  32'd31,        32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[8]  = '{SRL,  32'h8000_0000,  32'd31,        32'd1,          1'b0, 1'b0};
    vecs[9]  = '{SLA,  32'h4000_0001,  32'd1,         32'd2,          1'b0, 1'b0};
    vecs[10] = '{SIL,  32'hFFFF_FFFF,  32'd0,         32'd1,          1'b0, 1'b0};
    vecs[11] = '{SIE,  32'd9,          32'd9,         32'd1,          1'b0, 1'b0};
    vecs[12] = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  1'b0, 1'b0};
    vecs[13] = '{MOD,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,          1'b1, 1'b0};
    vecs[14] = '{UND,  32'd123,        32'd456,       32'd0,          1'b1, 1'b0};
    vecs[15] = '{NOR_, 32'd0,          32'd0,         32'hFFFF_FFFF,  1'b0, 1'b0};

    bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    bus.i_aluctl = '0; bus.i_a = '0; bus.i_b = '0;

    #1 rst_n = 1'b0;
    #2;
    chk("reset o_valid", 32'(bus.o_valid), 32'd0);
    chk("reset o_ready", 32'(bus.o_ready), 32'd1);
    chk("reset o_result", bus.o_result, 32'd0);
    chk("reset o_zero", 32'(bus.o_zero), 32'd0);
    chk("reset o_divz", 32'(bus.o_divz), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].res, vecs[i].z, vecs[i].dz, 0);

    // Back-pressure on both a single-cycle and a long op.
    do_op("bp_add", ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 5);
    do_op("bp_div", DIV, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 5);

    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick();
      b  = pick();
      model(op, a, b, r, dz);
      do_op($sformatf("rnd%0d", i), op, a, b, r, (r == 0), dz, int'($urandom_range(0, 2)));
    end

    // Flush in the 10th cycle of a DIV: no result, ready next cycle.
    bus.i_aluctl = DIV; bus.i_a = 32'd100; bus.i_b = 32'd7; bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (8) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("flush_calc ready", 32'(bus.o_ready), 32'd1);
    chk("flush_calc valid", 32'(bus.o_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.o_valid) seen = 1'b1; end
    chk("flush_calc no_result", 32'(seen), 32'd0);

    // Flush in DONE drops o_valid without a handshake.
    bus.i_aluctl = ADD; bus.i_a = 32'd1; bus.i_b = 32'd2; bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk("flush_done pre_valid", 32'(bus.o_valid), 32'd1);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("flush_done valid", 32'(bus.o_valid), 32'd0);
    chk("flush_done ready", 32'(bus.o_ready), 32'd1);

    // Flush together with i_valid in IDLE: no accept.
    bus.i_aluctl = ADD; bus.i_a = 32'd3; bus.i_b = 32'd4; bus.i_valid = 1'b1; bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_flush = 1'b0;
    chk("flush_idle valid", 32'(bus.o_valid), 32'd0);
    chk("flush_idle ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    chk("flush_idle valid2", 32'(bus.o_valid), 32'd0);
    do_op("after_flush", SUB, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0, 0);

    // Reset pulse mid-MUL: outputs return to reset values asynchronously.
    do_op("pre_rst", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
    bus.i_aluctl = MUL; bus.i_a = 32'd12345; bus.i_b = 32'd678; bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid valid", 32'(bus.o_valid), 32'd0);
    chk("rst_mid ready", 32'(bus.o_ready), 32'd1);
    chk("rst_mid result", bus.o_result, 32'd0);
    chk("rst_mid zero", 32'(bus.o_zero), 32'd0);
    chk("rst_mid divz", 32'(bus.o_divz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.o_valid) seen = 1'b1; end
    chk("rst_mid no_result", 32'(seen), 32'd0);
    do_op("post_rst", MUL, 32'd12345, 32'd678, 32'd8369910, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
